// File: rtl/branch_resolve_unit.sv
// ---------------------------------------------------------------------------
// branch_resolve_unit
//   Two-stage pipelined resolver for RISC-V conditional branches
//   (BEQ/BNE/BLT/BGE/BLTU/BGEU). S1 registers the incoming request, S2 holds
//   the resolved taken flag and redirect target until the consumer takes it.
//   A request presented in cycle N is delivered on out_* in cycle N+2 when
//   there is no stall.
//
// Ports
//   clk, rst             clock, asynchronous active-high reset
//   in_valid/in_ready    request handshake (in_ready low during flush/reset)
//   in_funct3            B-format funct3
//   in_rs1, in_rs2       operands
//   in_pc, in_imm        branch pc and sign-extended B-immediate
//   flush                drops every in-flight request at the next edge
//   out_valid/out_ready  result handshake; out_* held stable while stalled
//   out_taken            branch taken (never for an illegal funct3)
//   out_target           pc+imm when taken, pc+4 otherwise
//   out_misalign         taken and target breaks IALIGN
//   out_illegal          funct3 is 01x
//   cnt_branches         delivered results, saturating
//   cnt_taken            delivered taken results, saturating
// ---------------------------------------------------------------------------
module branch_resolve_unit #(
  parameter int XLEN   = 32,
  parameter int IALIGN = 32,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_funct3,
  input  logic [XLEN-1:0]  in_rs1,
  input  logic [XLEN-1:0]  in_rs2,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [XLEN-1:0]  in_imm,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_taken,
  output logic [XLEN-1:0]  out_target,
  output logic             out_misalign,
  output logic             out_illegal,
  output logic [CNT_W-1:0] cnt_branches,
  output logic [CNT_W-1:0] cnt_taken
);

  // S1: captured request
  logic            s1_valid_q,  s1_valid_d;
  logic [2:0]      s1_funct3_q, s1_funct3_d;
  logic [XLEN-1:0] s1_rs1_q,    s1_rs1_d;
  logic [XLEN-1:0] s1_rs2_q,    s1_rs2_d;
  logic [XLEN-1:0] s1_pc_q,     s1_pc_d;
  logic [XLEN-1:0] s1_imm_q,    s1_imm_d;

  // S2: resolved result
  logic            s2_valid_q,    s2_valid_d;
  logic            s2_taken_q,    s2_taken_d;
  logic [XLEN-1:0] s2_target_q,   s2_target_d;
  logic            s2_misalign_q, s2_misalign_d;
  logic            s2_illegal_q,  s2_illegal_d;

  logic [CNT_W-1:0] cnt_branches_q, cnt_branches_d;
  logic [CNT_W-1:0] cnt_taken_q,    cnt_taken_d;

  logic            s1_advance, in_fire, out_fire;
  logic            eq, lt, ltu, illegal, taken, misalign;
  logic [XLEN-1:0] br_target, seq_target, target;

  always_comb begin
    s1_advance = ~s2_valid_q | out_ready;
    // rst is included so in_ready is low for the whole time reset is asserted.
    in_ready   = ~rst & ~flush & (~s1_valid_q | s1_advance);
    in_fire    = in_valid & in_ready;
    out_fire   = s2_valid_q & out_ready;

    // Resolution of the request sitting in S1.
    eq  = (s1_rs1_q == s1_rs2_q);
    lt  = ($signed(s1_rs1_q) < $signed(s1_rs2_q));
    ltu = (s1_rs1_q < s1_rs2_q);

    illegal = 1'b0;
    taken   = 1'b0;
    unique case (s1_funct3_q)
      3'b000:  taken = eq;
      3'b001:  taken = ~eq;
      3'b100:  taken = lt;
      3'b101:  taken = ~lt;
      3'b110:  taken = ltu;
      3'b111:  taken = ~ltu;
      default: illegal = 1'b1;
    endcase

    // Modular adds; any carry out of XLEN is deliberately dropped.
    br_target  = s1_pc_q + s1_imm_q;
    seq_target = s1_pc_q + XLEN'(4);
    target     = taken ? br_target : seq_target;

    if (IALIGN == 16) misalign = taken & br_target[0];
    else              misalign = taken & (|br_target[1:0]);

    // S1 next state
    s1_funct3_d = s1_funct3_q;
    s1_rs1_d    = s1_rs1_q;
    s1_rs2_d    = s1_rs2_q;
    s1_pc_d     = s1_pc_q;
    s1_imm_d    = s1_imm_q;
    if (in_fire) begin
      s1_funct3_d = in_funct3;
      s1_rs1_d    = in_rs1;
      s1_rs2_d    = in_rs2;
      s1_pc_d     = in_pc;
      s1_imm_d    = in_imm;
    end
    if (flush)           s1_valid_d = 1'b0;
    else if (in_fire)    s1_valid_d = 1'b1;
    else if (s1_advance) s1_valid_d = 1'b0;
    else                 s1_valid_d = s1_valid_q;

    // S2 next state: payload only changes when a real request moves in, so
    // a stalled result stays bit-for-bit stable.
    s2_valid_d    = s2_valid_q;
    s2_taken_d    = s2_taken_q;
    s2_target_d   = s2_target_q;
    s2_misalign_d = s2_misalign_q;
    s2_illegal_d  = s2_illegal_q;
    if (s1_advance) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_taken_d    = taken;
        s2_target_d   = target;
        s2_misalign_d = misalign;
        s2_illegal_d  = illegal;
      end
    end
    if (flush) s2_valid_d = 1'b0;

    // Saturating statistics
    cnt_branches_d = cnt_branches_q;
    cnt_taken_d    = cnt_taken_q;
    if (out_fire && (cnt_branches_q != {CNT_W{1'b1}}))
      cnt_branches_d = cnt_branches_q + CNT_W'(1);
    if (out_fire && s2_taken_q && (cnt_taken_q != {CNT_W{1'b1}}))
      cnt_taken_d = cnt_taken_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q     <= 1'b0;
      s1_funct3_q    <= '0;
      s1_rs1_q       <= '0;
      s1_rs2_q       <= '0;
      s1_pc_q        <= '0;
      s1_imm_q       <= '0;
      s2_valid_q     <= 1'b0;
      s2_taken_q     <= 1'b0;
      s2_target_q    <= '0;
      s2_misalign_q  <= 1'b0;
      s2_illegal_q   <= 1'b0;
      cnt_branches_q <= '0;
      cnt_taken_q    <= '0;
    end else begin
      s1_valid_q     <= s1_valid_d;
      s1_funct3_q    <= s1_funct3_d;
      s1_rs1_q       <= s1_rs1_d;
      s1_rs2_q       <= s1_rs2_d;
      s1_pc_q        <= s1_pc_d;
      s1_imm_q       <= s1_imm_d;
      s2_valid_q     <= s2_valid_d;
      s2_taken_q     <= s2_taken_d;
      s2_target_q    <= s2_target_d;
      s2_misalign_q  <= s2_misalign_d;
      s2_illegal_q   <= s2_illegal_d;
      cnt_branches_q <= cnt_branches_d;
      cnt_taken_q    <= cnt_taken_d;
    end
  end

  assign out_valid    = s2_valid_q;
  assign out_taken    = s2_taken_q;
  assign out_target   = s2_target_q;
  assign out_misalign = s2_misalign_q;
  assign out_illegal  = s2_illegal_q;
  assign cnt_branches = cnt_branches_q;
  assign cnt_taken    = cnt_taken_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// ---------------------------------------------------------------------------
// tb_branch_resolve_unit
//   Directed bench for branch_resolve_unit. A second instance with CNT_W=2
//   shares every input so counter saturation is observed on the same traffic.
// ---------------------------------------------------------------------------
module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready, in_ready_2;
  logic [2:0]  in_funct3;
  logic [31:0] in_rs1, in_rs2, in_pc, in_imm;
  logic        flush;
  logic        out_valid, out_valid_2;
  logic        out_ready;
  logic        out_taken, out_taken_2;
  logic [31:0] out_target, out_target_2;
  logic        out_misalign, out_misalign_2;
  logic        out_illegal, out_illegal_2;
  logic [15:0] cnt_branches, cnt_taken;
  logic [1:0]  cnt_branches_2, cnt_taken_2;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  branch_resolve_unit #(.XLEN(32), .IALIGN(32), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_funct3(in_funct3), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_pc(in_pc),
    .in_imm(in_imm), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_taken(out_taken), .out_target(out_target), .out_misalign(out_misalign),
    .out_illegal(out_illegal), .cnt_branches(cnt_branches), .cnt_taken(cnt_taken)
  );

  branch_resolve_unit #(.XLEN(32), .IALIGN(32), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_2),
    .in_funct3(in_funct3), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_pc(in_pc),
    .in_imm(in_imm), .flush(flush), .out_valid(out_valid_2), .out_ready(out_ready),
    .out_taken(out_taken_2), .out_target(out_target_2), .out_misalign(out_misalign_2),
    .out_illegal(out_illegal_2), .cnt_branches(cnt_branches_2), .cnt_taken(cnt_taken_2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Drive one request for one clock edge (called right after a negedge).
  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] pc, input logic [31:0] imm);
    in_valid = 1'b1; in_funct3 = f3; in_rs1 = a; in_rs2 = b; in_pc = pc; in_imm = imm;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic expect_out(input string tag, input logic tk, input logic [31:0] tgt,
                            input logic mis, input logic ill);
    chk({tag, "_valid"},    out_valid,    32'd1);
    chk({tag, "_taken"},    out_taken,    tk);
    chk({tag, "_target"},   out_target,   tgt);
    chk({tag, "_misalign"}, out_misalign, mis);
    chk({tag, "_illegal"},  out_illegal,  ill);
    $display("txn %s taken=%0d target=0x%08h mis=%0d ill=%0d",
             tag, out_taken, out_target, out_misalign, out_illegal);
  endtask

  // Single request, result checked two cycles after presentation.
  task automatic one(input string tag, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] pc, input logic [31:0] imm,
                     input logic tk, input logic [31:0] tgt, input logic mis, input logic ill);
    issue(f3, a, b, pc, imm);
    chk({tag, "_early"}, out_valid, 32'd0);
    @(negedge clk);
    expect_out(tag, tk, tgt, mis, ill);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_funct3 = '0; in_rs1 = '0; in_rs2 = '0;
    in_pc = '0; in_imm = '0; flush = 1'b0; out_ready = 1'b1;

    // Reset state
    @(negedge clk);
    chk("rst_in_ready",  in_ready,     32'd0);
    chk("rst_out_valid", out_valid,    32'd0);
    chk("rst_target",    out_target,   32'd0);
    chk("rst_cnt",       cnt_branches, 32'd0);
    rst = 1'b0;
    #1 chk("rel_in_ready", in_ready, 32'd1);
    @(negedge clk);

    // Single-request directed vectors (out_ready=1, each delivered once)
    one("beq",   3'b000, 32'hDEADBEEF, 32'hDEADBEEF, 32'h100, 32'h20, 1'b1, 32'h120, 1'b0, 1'b0);
    one("blt",   3'b100, 32'hFFFFFFFF, 32'h1, 32'h200, 32'h40, 1'b1, 32'h240, 1'b0, 1'b0);
    one("bltu",  3'b110, 32'hFFFFFFFF, 32'h1, 32'h200, 32'h40, 1'b0, 32'h204, 1'b0, 1'b0);
    one("ill",   3'b010, 32'h5, 32'h5, 32'h300, 32'h8, 1'b0, 32'h304, 1'b0, 1'b1);
    one("mis",   3'b000, 32'h5, 32'h5, 32'h100, 32'h2, 1'b1, 32'h102, 1'b1, 1'b0);
    one("wrap",  3'b001, 32'h1, 32'h2, 32'hFFFFFFF0, 32'h20, 1'b1, 32'h10, 1'b0, 1'b0);
    one("bge",   3'b101, 32'h3, 32'hFFFFFFFF, 32'h400, 32'hFFFFFFF0, 1'b1, 32'h3F0, 1'b0, 1'b0);
    @(negedge clk);  // last result consumed
    chk("cnt_br_7",   cnt_branches,   32'd7);
    chk("cnt_tk_5",   cnt_taken,      32'd5);
    chk("cnt2_br_sat", cnt_branches_2, 32'd3);
    chk("cnt2_tk_sat", cnt_taken_2,    32'd3);

    // Back-to-back with backpressure: A,B enter; C stalls until out_ready.
    out_ready = 1'b0;
    issue(3'b000, 32'h7, 32'h7, 32'h1000, 32'h10);   // A taken -> 0x1010
    issue(3'b001, 32'h7, 32'h7, 32'h2000, 32'h10);   // B not taken -> 0x2004
    in_valid = 1'b1; in_funct3 = 3'b110; in_rs1 = 32'h1; in_rs2 = 32'h2;
    in_pc = 32'h3000; in_imm = 32'h100;              // C taken -> 0x3100
    #1 chk("bp_in_ready_lo", in_ready, 32'd0);
    expect_out("bp_a_stall1", 1'b1, 32'h1010, 1'b0, 1'b0);
    @(negedge clk);
    chk("bp_in_ready_lo2", in_ready, 32'd0);
    expect_out("bp_a_stall2", 1'b1, 32'h1010, 1'b0, 1'b0);
    @(negedge clk);
    expect_out("bp_a_stall3", 1'b1, 32'h1010, 1'b0, 1'b0);
    out_ready = 1'b1;
    #1 chk("bp_in_ready_hi", in_ready, 32'd1);
    @(negedge clk);                                  // A out, C accepted
    in_funct3 = 3'b111; in_rs1 = 32'h1; in_rs2 = 32'h2;
    in_pc = 32'h4000; in_imm = 32'h8;                // D not taken -> 0x4004
    expect_out("bp_b", 1'b0, 32'h2004, 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    expect_out("bp_c", 1'b1, 32'h3100, 1'b0, 1'b0);
    @(negedge clk);
    expect_out("bp_d", 1'b0, 32'h4004, 1'b0, 1'b0);
    @(negedge clk);
    chk("cnt_br_11", cnt_branches, 32'd11);
    chk("cnt_tk_7",  cnt_taken,    32'd7);
    chk("bp_drained", out_valid,   32'd0);

    // Flush with both stages full
    out_ready = 1'b0;
    issue(3'b000, 32'h9, 32'h9, 32'h500, 32'h10);
    issue(3'b000, 32'h9, 32'h9, 32'h600, 32'h10);
    chk("fl_full_valid", out_valid, 32'd1);
    in_valid = 1'b1; in_pc = 32'h700; flush = 1'b1;
    #1 chk("fl_in_ready", in_ready, 32'd0);
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_s2_empty", out_valid, 32'd0);
    out_ready = 1'b1;
    @(negedge clk);
    chk("fl_s1_empty", out_valid,    32'd0);
    chk("fl_cnt",      cnt_branches, 32'd11);
    $display("txn flush cnt_branches=%0d", cnt_branches);

    // Asynchronous reset mid-stall
    out_ready = 1'b0;
    issue(3'b000, 32'h9, 32'h9, 32'h500, 32'h10);
    issue(3'b000, 32'h9, 32'h9, 32'h600, 32'h10);
    chk("rs_taken_pre", out_taken, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rs_out_valid", out_valid,    32'd0);
    chk("rs_taken",     out_taken,    32'd0);
    chk("rs_target",    out_target,   32'd0);
    chk("rs_cnt_br",    cnt_branches, 32'd0);
    chk("rs_cnt_tk",    cnt_taken,    32'd0);
    chk("rs_in_ready",  in_ready,     32'd0);
    $display("txn async_reset out_valid=%0d", out_valid);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("rs_rel_ready", in_ready, 32'd1);
    @(negedge clk);
    chk("rs_idle", out_valid, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
